// File: rtl/qtr_array_reader.sv
// QTR reflectance array reader: emits, charges and times the RC decay of up to
// NUM_CH sensors, then publishes per-channel decay times and a dark/light mask.
module qtr_array_reader #(
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = 16,
  parameter int EMIT_CYC    = 160,
  parameter int CHARGE_CYC  = 160,
  parameter int TIMEOUT_CYC = 48000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    cont_mode,
  input  logic [NUM_CH-1:0]       channel_sel,
  input  logic [CNT_W-1:0]        threshold,
  input  logic [NUM_CH-1:0]       sensor_in,
  output logic [NUM_CH-1:0]       sensor_oe,
  output logic                    led_even,
  output logic                    led_odd,
  output logic [NUM_CH*CNT_W-1:0] ttd,
  output logic [NUM_CH-1:0]       line_bits,
  output logic                    busy,
  output logic                    frame_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_CHARGE,
    S_DECAY,
    S_PUBLISH
  } state_t;

  localparam logic [CNT_W-1:0] L_EMIT_LAST   = CNT_W'(EMIT_CYC - 1);
  localparam logic [CNT_W-1:0] L_CHARGE_LAST = CNT_W'(CHARGE_CYC - 1);
  localparam logic [CNT_W-1:0] L_TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] L_TIMEOUT     = CNT_W'(TIMEOUT_CYC);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [NUM_CH-1:0]       r_sync1;
  logic [NUM_CH-1:0]       r_sync2;
  logic [NUM_CH-1:0]       r_sel_q;
  logic [NUM_CH-1:0]       r_captured;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_cap [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] r_ttd;
  logic [NUM_CH-1:0]       r_line_bits;

  logic [NUM_CH-1:0]       w_hit;
  logic [NUM_CH-1:0]       w_done_mask;
  logic [CNT_W-1:0]        w_cap_next [NUM_CH];
  logic                    w_all_done;
  logic                    w_decay_end;
  logic                    w_any_even;
  logic                    w_any_odd;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sensor_in;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_hit[i] = (r_state == S_DECAY) && r_sel_q[i] && !r_captured[i] && !r_sync2[i];
    end
    w_done_mask = (r_captured | w_hit) & r_sel_q;
    w_all_done  = (w_done_mask == r_sel_q);
    w_decay_end = (r_state == S_DECAY) && enable && (w_all_done || (r_cnt == L_TO_LAST));
    // A capture on the final decay cycle takes priority over saturation.
    for (int i = 0; i < NUM_CH; i++) begin
      w_cap_next[i] = r_cap[i];
      if (w_hit[i]) begin
        w_cap_next[i] = r_cnt;
      end else if (w_decay_end && r_sel_q[i] && !r_captured[i]) begin
        w_cap_next[i] = L_TIMEOUT;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable && start && (|channel_sel)) w_state_next = S_EMIT;
      end
      S_EMIT: begin
        if (!enable)                    w_state_next = S_IDLE;
        else if (r_cnt == L_EMIT_LAST)  w_state_next = S_CHARGE;
      end
      S_CHARGE: begin
        if (!enable)                     w_state_next = S_IDLE;
        else if (r_cnt == L_CHARGE_LAST) w_state_next = S_DECAY;
      end
      S_DECAY: begin
        if (!enable)         w_state_next = S_IDLE;
        else if (w_decay_end) w_state_next = S_PUBLISH;
      end
      S_PUBLISH: begin
        w_state_next = (enable && cont_mode) ? S_EMIT : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_any_even = 1'b0;
    w_any_odd  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((i % 2) == 0) w_any_even = w_any_even | r_sel_q[i];
      else              w_any_odd  = w_any_odd  | r_sel_q[i];
    end
  end

  // NOTE: the small cap array is reset explicitly since it is a handful of flops, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sel_q     <= '0;
      r_captured  <= '0;
      r_ttd       <= '0;
      r_line_bits <= '0;
      for (int i = 0; i < NUM_CH; i++) r_cap[i] <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_state_next != r_state)  r_cnt <= '0;
      else if (r_state != S_IDLE)   r_cnt <= r_cnt + CNT_W'(1);

      if ((w_state_next == S_EMIT) && (r_state != S_EMIT)) r_sel_q <= channel_sel;

      if ((r_state == S_CHARGE) && (w_state_next == S_DECAY)) begin
        r_captured <= '0;
        for (int i = 0; i < NUM_CH; i++) r_cap[i] <= '0;
      end else if (r_state == S_DECAY) begin
        r_captured <= r_captured | w_hit;
        for (int i = 0; i < NUM_CH; i++) r_cap[i] <= w_cap_next[i];
      end

      // Results land on the edge into PUBLISH so they are valid alongside frame_valid.
      if (w_decay_end) begin
        for (int i = 0; i < NUM_CH; i++) begin
          r_ttd[i*CNT_W +: CNT_W] <= r_sel_q[i] ? w_cap_next[i] : '0;
          r_line_bits[i]          <= r_sel_q[i] && (w_cap_next[i] >= threshold);
        end
      end
    end
  end

  assign sensor_oe   = (r_state == S_CHARGE) ? r_sel_q : '0;
  assign led_even    = ((r_state == S_EMIT) || (r_state == S_CHARGE) || (r_state == S_DECAY)) && w_any_even;
  assign led_odd     = ((r_state == S_EMIT) || (r_state == S_CHARGE) || (r_state == S_DECAY)) && w_any_odd;
  assign busy        = (r_state != S_IDLE);
  assign frame_valid = (r_state == S_PUBLISH);
  assign ttd         = r_ttd;
  assign line_bits   = r_line_bits;

endmodule
